// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, status bit positions, FSM and iterator encodings.
// Op_MUL only has a function when ALU_MUL_EN is defined; otherwise 0_1010 is a reserved opcode.
package alu_pkg;

    localparam logic [4:0] Op_NOP  = 5'b0_0000;
    localparam logic [4:0] Op_ADD  = 5'b0_0001;
    localparam logic [4:0] Op_SUB  = 5'b0_0010;
    localparam logic [4:0] Op_AND  = 5'b0_0011;
    localparam logic [4:0] Op_OR   = 5'b0_0100;
    localparam logic [4:0] Op_NOT  = 5'b0_0101;
    localparam logic [4:0] Op_XOR  = 5'b0_0110;
    localparam logic [4:0] Op_SHL  = 5'b0_0111;
    localparam logic [4:0] Op_SHR  = 5'b0_1000;
    // VAL is consumed outside the ALU; here it completes like NOP.
    localparam logic [4:0] Op_VAL  = 5'b0_1001;
    localparam logic [4:0] OP_RES0 = 5'b0_1010;
    localparam logic [4:0] OP_RES1 = 5'b0_1011;
    localparam logic [4:0] OP_RES2 = 5'b0_1100;
    localparam logic [4:0] OP_RES3 = 5'b0_1101;
    localparam logic [4:0] OP_RES4 = 5'b0_1110;
    localparam logic [4:0] OP_RES5 = 5'b0_1111;
    localparam logic [4:0] Op_GOTO = 5'b1_0000;
    localparam logic [4:0] Op_IFEQ = 5'b1_0001;
    localparam logic [4:0] Op_IFNE = 5'b1_0010;
    localparam logic [4:0] Op_IFLT = 5'b1_0011;
    localparam logic [4:0] Op_IFGT = 5'b1_0100;
    localparam logic [4:0] Op_MUL  = 5'b0_1010;

    localparam int STAT_CARRY     = 0;
    localparam int STAT_UNDERFLOW = 1;
    localparam int STAT_ZERO      = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        IT_SHL = 2'd0,
        IT_SHR = 2'd1,
        IT_MUL = 2'd2
    } iter_mode_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one-bit-per-cycle SHL/SHR and, with ALU_MUL_EN, an unsigned shift-add multiplier.
// A down-counter runs the steps; done is high during the final step so the caller captures result/carry then.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int CntW      = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  iter_mode_t           mode,
    input  logic [DataWidth-1:0] opa,
`ifdef ALU_MUL_EN
    input  logic [DataWidth-1:0] opb,
`endif
    input  logic [CntW-1:0]      count,
    output logic                 done,
    output logic [DataWidth-1:0] result,
    output logic                 carry
);

    logic [CntW-1:0]      cnt;
    iter_mode_t           mode_q;
    logic [DataWidth-1:0] lo_q, lo_d;
    logic                 cy_q, cy_d;
`ifdef ALU_MUL_EN
    logic [DataWidth-1:0] hi_q, hi_d, mcand_q, addend;
    logic [DataWidth:0]   sum;
`endif

    always_comb begin
        lo_d = lo_q;
        cy_d = cy_q;
`ifdef ALU_MUL_EN
        hi_d   = hi_q;
        addend = lo_q[0] ? mcand_q : '0;
        sum    = {1'b0, hi_q} + {1'b0, addend};
`endif
        case (mode_q)
            IT_SHL: begin
                lo_d = {lo_q[DataWidth-2:0], 1'b0};
                cy_d = lo_q[DataWidth-1];
            end
            IT_SHR: begin
                lo_d = {1'b0, lo_q[DataWidth-1:1]};
                cy_d = lo_q[0];
            end
`ifdef ALU_MUL_EN
            // Product accumulates in {hi,lo}; multiplier bits drain out of lo.
            IT_MUL: begin
                hi_d = sum[DataWidth:1];
                lo_d = {sum[0], lo_q[DataWidth-1:1]};
                cy_d = |sum[DataWidth:1];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            mode_q  <= IT_SHL;
            lo_q    <= '0;
            cy_q    <= 1'b0;
`ifdef ALU_MUL_EN
            hi_q    <= '0;
            mcand_q <= '0;
`endif
        end else if (start) begin
            cnt     <= count;
            mode_q  <= mode;
            lo_q    <= opa;
            cy_q    <= 1'b0;
`ifdef ALU_MUL_EN
            hi_q    <= '0;
            mcand_q <= opb;
`endif
        end else if (cnt != '0) begin
            cnt  <= cnt - CntW'(1);
            lo_q <= lo_d;
            cy_q <= cy_d;
`ifdef ALU_MUL_EN
            hi_q <= hi_d;
`endif
        end
    end

    assign done   = (cnt == CntW'(1));
    assign result = lo_d;
    assign carry  = cy_d;

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshake; single-cycle ops resolve at accept, shifts (and MUL) iterate.
// Optional multiplier enabled by defining ALU_MUL_EN.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for in_valid
// ST_ITER | alu_iter_unit stepping a shift or multiply
// ST_DONE | out_valid=1, result/status held until out_ready
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DataWidth     = 8,
    parameter int NumOpCodeBits = 5,
    parameter int ParamBits     = 8,
    parameter int NumStatusBits = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NumOpCodeBits-1:0] opcode,
    input  logic [DataWidth-1:0]     operand1,
    input  logic [DataWidth-1:0]     operand2,
    input  logic [ParamBits-1:0]     param,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DataWidth-1:0]     result,
    output logic [NumStatusBits-1:0] status
);

    localparam int CntW = $clog2(DataWidth + 1);

    alu_state_t               state, state_nxt;
    logic [DataWidth-1:0]     result_nxt, iter_result;
    logic [NumStatusBits-1:0] status_nxt;
    logic [DataWidth:0]       sum;
    logic [CntW-1:0]          shamt, iter_count;
    logic                     iter_start, iter_done, iter_carry, zero_en;
    iter_mode_t               iter_mode;

    assign shamt = (32'(param) > DataWidth) ? CntW'(DataWidth) : CntW'(param);
    assign sum   = {1'b0, operand1} + {1'b0, operand2};

    alu_iter_unit #(.DataWidth(DataWidth), .CntW(CntW)) u_iter (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (iter_start),
        .mode    (iter_mode),
        .opa     (operand1),
`ifdef ALU_MUL_EN
        .opb     (operand2),
`endif
        .count   (iter_count),
        .done    (iter_done),
        .result  (iter_result),
        .carry   (iter_carry)
    );

    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        status_nxt = status;
        iter_start = 1'b0;
        iter_mode  = (opcode == Op_SHR) ? IT_SHR : IT_SHL;
        iter_count = shamt;
        zero_en    = 1'b0;
        case (state)
            ST_IDLE: if (in_valid) begin
                state_nxt  = ST_DONE;
                result_nxt = '0;
                status_nxt = '0;
                zero_en    = 1'b1;
                case (opcode)
                    Op_ADD: begin
                        result_nxt             = sum[DataWidth-1:0];
                        status_nxt[STAT_CARRY] = sum[DataWidth];
                    end
                    Op_SUB: begin
                        result_nxt                 = operand1 - operand2;
                        status_nxt[STAT_UNDERFLOW] = (operand2 > operand1);
                    end
                    Op_AND: result_nxt = operand1 & operand2;
                    Op_OR:  result_nxt = operand1 | operand2;
                    Op_XOR: result_nxt = operand1 ^ operand2;
                    Op_NOT: result_nxt = ~operand2;
                    Op_SHL, Op_SHR: begin
                        if (shamt == '0) begin
                            result_nxt = operand1;
                        end else begin
                            iter_start = 1'b1;
                            state_nxt  = ST_ITER;
                            result_nxt = result;
                            status_nxt = status;
                            zero_en    = 1'b0;
                        end
                    end
`ifdef ALU_MUL_EN
                    Op_MUL: begin
                        iter_start = 1'b1;
                        iter_mode  = IT_MUL;
                        iter_count = CntW'(DataWidth);
                        state_nxt  = ST_ITER;
                        result_nxt = result;
                        status_nxt = status;
                        zero_en    = 1'b0;
                    end
`endif
                    default: zero_en = 1'b0;
                endcase
            end
            ST_ITER: if (iter_done) begin
                state_nxt              = ST_DONE;
                result_nxt             = iter_result;
                status_nxt             = '0;
                status_nxt[STAT_CARRY] = iter_carry;
                zero_en                = 1'b1;
            end
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (zero_en) status_nxt[STAT_ZERO] = (result_nxt == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            result <= '0;
            status <= '0;
        end else begin
            state  <= state_nxt;
            result <= result_nxt;
            status <= status_nxt;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle; expectations for opcode 0_1010 follow ALU_MUL_EN.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] opcode = '0;
    logic [7:0] operand1 = '0, operand2 = '0, param = '0;
    logic       in_ready, out_valid;
    logic [7:0] result;
    logic [2:0] status;

    int vectors = 0;
    int miscompares = 0;

    alu_multicycle dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand1  (operand1),
        .operand2  (operand2),
        .param     (param),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .status    (status)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] p, input logic [7:0] er,
                          input logic [2:0] es, input int el);
        int lat;
        @(negedge clock);
        chk({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1; opcode = op; operand1 = a; operand2 = b; param = p;
        @(posedge clock); #1;
        // Scramble inputs after accept: the result must come from latched values.
        in_valid = 1'b0; opcode = Op_ADD; operand1 = ~a; operand2 = ~b; param = 8'd5;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, el);
        chk({tag, ".result"}, result, er);
        chk({tag, ".status"}, status, es);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({tag, ".released"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset.state", {out_valid, result, status}, 12'h000);
        reset_n = 1'b1;
        #1 chk("reset.in_ready", in_ready, 1);

        run_op("add_carry",  Op_ADD,  8'd200, 8'd100, 8'd0,  8'd44,  3'b001, 1);
        run_op("sub_under",  Op_SUB,  8'd5,   8'd7,   8'd0,  8'd254, 3'b010, 1);
        run_op("sub_zero",   Op_SUB,  8'd9,   8'd9,   8'd0,  8'd0,   3'b100, 1);
        run_op("add_wrap",   Op_ADD,  8'hFF,  8'h01,  8'd0,  8'h00,  3'b101, 1);
        run_op("and",        Op_AND,  8'hF0,  8'h3C,  8'd0,  8'h30,  3'b000, 1);
        run_op("or_zero",    Op_OR,   8'h00,  8'h00,  8'd0,  8'h00,  3'b100, 1);
        run_op("xor",        Op_XOR,  8'hAA,  8'hFF,  8'd0,  8'h55,  3'b000, 1);
        run_op("not",        Op_NOT,  8'h12,  8'h0F,  8'd0,  8'hF0,  3'b000, 1);
        run_op("nop",        Op_NOP,  8'h12,  8'h34,  8'd0,  8'h00,  3'b000, 1);
        run_op("goto",       Op_GOTO, 8'h00,  8'h00,  8'd0,  8'h00,  3'b000, 1);
        run_op("shl3",       Op_SHL,  8'h81,  8'h00,  8'd3,  8'h08,  3'b000, 4);
        run_op("shr1",       Op_SHR,  8'h81,  8'h00,  8'd1,  8'h40,  3'b001, 2);
        run_op("shl_clamp",  Op_SHL,  8'h81,  8'h00,  8'd12, 8'h00,  3'b101, 9);
        run_op("shl0",       Op_SHL,  8'h81,  8'h00,  8'd0,  8'h81,  3'b000, 1);
        run_op("shr8",       Op_SHR,  8'h80,  8'h00,  8'd8,  8'h00,  3'b101, 9);
`ifdef ALU_MUL_EN
        run_op("mul",        Op_MUL,  8'd16,  8'd17,  8'd0,  8'd16,  3'b001, 9);
`else
        run_op("mul_res",    Op_MUL,  8'd16,  8'd17,  8'd0,  8'd0,   3'b000, 1);
`endif

        // Backpressure: DONE holds while a new operation is offered.
        @(negedge clock);
        in_valid = 1'b1; opcode = Op_SUB; operand1 = 8'd9; operand2 = 8'd9;
        @(posedge clock); #1;
        chk("bp.valid", out_valid, 1);
        opcode = Op_ADD; operand1 = 8'd1; operand2 = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("bp.hold", {out_valid, in_ready, result, status}, {1'b1, 1'b0, 8'd0, 3'b100});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("bp.release", {out_valid, in_ready}, 2'b01);
        @(posedge clock); #1;
        chk("bp.no_accept", {out_valid, in_ready, result}, {2'b01, 8'd0});

        // Reset during the 4th ITER cycle of an 8-step SHL.
        run_op("pre_reset", Op_ADD, 8'd200, 8'd100, 8'd0, 8'd44, 3'b001, 1);
        @(negedge clock);
        in_valid = 1'b1; opcode = Op_SHL; operand1 = 8'h81; param = 8'd8;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1 chk("midreset.outs", {out_valid, result, status}, 12'h000);
        @(negedge clock);
        reset_n = 1'b1;
        #1 chk("midreset.in_ready", in_ready, 1);
        run_op("post_reset", Op_ADD, 8'd1, 8'd2, 8'd0, 8'd3, 3'b000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
